parking_system_adv: RTL and testbench

PARKING_SYSTEM_ADV -- requirements
Module: parking_system_adv

---
 rtl/parking_system_adv.sv | 97 +++++++++
 tb/tb_parking_system_adv.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/parking_system_adv.sv
// Purpose: parking gate controller; opens the gate after a wait window and a correct access code.
// Latency: state and counter update on each rising clk edge; out is a Moore decode of the state register.
// Backpressure: none; sensor and pass are sampled every edge and the block never stalls.
module parking_system_adv #(
    parameter logic [3:0] PASSWORD    = 4'b1010,
    parameter int         WAIT_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sensor,
    input  logic [3:0]  pass,
    output logic        out,
    output logic [63:0] counter_wait
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PASS  = 2'd1,
        WRONG_PASS = 2'd2,
        GRANTED    = 2'd3
    } state_t;

    // The code is first examined on the edge where the count reaches WAIT_CYCLES-1,
    // so the count reads WAIT_CYCLES when the verdict state is entered.
    localparam logic [63:0] CHECK_AT = 64'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] cnt_nxt;
    logic [63:0] cnt_inc;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_inc = (counter_wait == '1) ? counter_wait : counter_wait + 64'd1;
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            counter_wait <= '0;
        end else begin
            state        <= state_nxt;
            counter_wait <= cnt_nxt;
        end
    end

    // Next-state and next-count decode; a dropped sensor always wins and clears the count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = counter_wait;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (sensor) begin
                    state_nxt = WAIT_PASS;
                end
            end
            WAIT_PASS: begin
                if (!sensor) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (counter_wait == CHECK_AT) begin
                        state_nxt = (pass == PASSWORD) ? GRANTED : WRONG_PASS;
                    end
                end
            end
            WRONG_PASS: begin
                if (!sensor) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (pass == PASSWORD) begin
                        state_nxt = GRANTED;
                    end
                end
            end
            GRANTED: begin
                if (!sensor) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Gate open exactly while the registered state is GRANTED.
    assign out = (state == GRANTED);

endmodule

// File: tb/tb_parking_system_adv.sv
// Bench for parking_system_adv: directed vector table, a pass-glitch sequence, then random traffic.
// Expected values come from the table constants or a session-level reference model.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_parking_system_adv;

    localparam logic [3:0] PW = 4'b1010;
    localparam int         WC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sensor;
    logic [3:0]  pass;
    logic        out;
    logic [63:0] counter_wait;

    int vectors     = 0;
    int miscompares = 0;

    parking_system_adv #(.PASSWORD(PW), .WAIT_CYCLES(WC)) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor       (sensor),
        .pass         (pass),
        .out          (out),
        .counter_wait (counter_wait)
    );

    always #5 clk = ~clk;

    // Reference model: a vehicle "session" with a granted flag and a wait count.
    bit          m_session;
    bit          m_granted;
    logic [63:0] m_cnt;

    task automatic model_edge(input logic r, input logic s, input logic [3:0] p);
        if (!r || !s) begin
            m_session = 0;
            m_granted = 0;
            m_cnt     = 64'd0;
        end else if (!m_session) begin
            m_session = 1;
            m_cnt     = 64'd0;
        end else if (!m_granted) begin
            // Code is looked at once the wait window has elapsed, then every cycle after.
            if (m_cnt >= 64'(WC - 1) && p == PW) m_granted = 1;
            if (m_cnt != {64{1'b1}}) m_cnt = m_cnt + 64'd1;
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic [3:0] p);
        reset  = r;
        sensor = s;
        pass   = p;
        @(posedge clk);
        model_edge(r, s, p);
        #1;
    endtask

    task automatic check(input string name, input logic exp_out, input logic [63:0] exp_cnt);
        vectors++;
        if (out !== exp_out || counter_wait !== exp_cnt) begin
            miscompares++;
            $display("FAIL %s: got out=%b counter_wait=%0d, expected out=%b counter_wait=%0d",
                     name, out, counter_wait, exp_out, exp_cnt);
        end
    endtask

    typedef struct {
        string       name;
        logic        r;
        logic        s;
        logic [3:0]  p;
        logic        e_out;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n, input logic r, input logic s, input logic [3:0] p,
                       input logic eo, input int ec);
        vec_t v;
        v.name = n; v.r = r; v.s = s; v.p = p; v.e_out = eo; v.e_cnt = 64'(ec);
        tbl.push_back(v);
    endtask

    initial begin
        reset  = 1'b0;
        sensor = 1'b0;
        pass   = 4'b0000;

        // Reset held with vehicle present
        add("rst0", 0, 1, PW,      0, 0);
        add("rst1", 0, 1, PW,      0, 0);
        // Correct code: enter, count 1..3, grant at 4, hold regardless of pass
        add("ok_enter", 1, 1, PW,  0, 0);
        add("ok_c1",    1, 1, PW,  0, 1);
        add("ok_c2",    1, 1, PW,  0, 2);
        add("ok_c3",    1, 1, PW,  0, 3);
        add("ok_grant", 1, 1, PW,  1, 4);
        add("ok_hold",  1, 1, 4'h0, 1, 4);
        add("ok_hold2", 1, 1, 4'h5, 1, 4);
        // Exit from GRANTED
        add("exit",     1, 0, PW,  0, 0);
        // Wrong then right
        add("wr_enter", 1, 1, 4'h0, 0, 0);
        add("wr_c1",    1, 1, 4'h0, 0, 1);
        add("wr_c2",    1, 1, 4'h0, 0, 2);
        add("wr_c3",    1, 1, 4'h0, 0, 3);
        add("wr_wrong", 1, 1, 4'h0, 0, 4);
        add("wr_c5",    1, 1, 4'h0, 0, 5);
        add("wr_c6",    1, 1, 4'hB, 0, 6);
        add("wr_c7",    1, 1, 4'h0, 0, 7);
        add("wr_right", 1, 1, PW,  1, 8);
        add("wr_frozen",1, 1, 4'h0, 1, 8);
        // Mid-operation reset while granted, then re-grant 4 edges after release
        add("mr_rst",   0, 1, PW,  0, 0);
        add("mr_enter", 1, 1, PW,  0, 0);
        add("mr_c1",    1, 1, PW,  0, 1);
        add("mr_c2",    1, 1, PW,  0, 2);
        add("mr_c3",    1, 1, PW,  0, 3);
        add("mr_grant", 1, 1, PW,  1, 4);
        // Abort at count 2, then restart from 0
        add("ab_idle",  1, 0, 4'h0, 0, 0);
        add("ab_enter", 1, 1, 4'h0, 0, 0);
        add("ab_c1",    1, 1, 4'h0, 0, 1);
        add("ab_c2",    1, 1, PW,  0, 2);
        add("ab_drop",  1, 0, PW,  0, 0);
        add("ab_idle2", 1, 0, PW,  0, 0);
        add("ab_again", 1, 1, 4'h0, 0, 0);
        add("ab_r1",    1, 1, 4'h0, 0, 1);
        // Reset while in WRONG_PASS
        add("ab_r2",    1, 1, 4'h0, 0, 2);
        add("ab_r3",    1, 1, 4'h0, 0, 3);
        add("ab_wrong", 1, 1, 4'h0, 0, 4);
        add("wp_rst",   0, 1, PW,  0, 0);
        add("wp_rel",   1, 1, PW,  0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].s, tbl[i].p);
            check(tbl[i].name, tbl[i].e_out, tbl[i].e_cnt);
        end

        // Pass glitch between edges must be ignored while in WRONG_PASS.
        apply(0, 0, 4'h0);
        check("gl_rst", 1'b0, 64'd0);
        for (int i = 0; i <= WC; i++) apply(1, 1, 4'h0);
        check("gl_wrong", 1'b0, 64'(WC));
        pass = PW;
        #3;
        pass = 4'h0;
        @(posedge clk);
        model_edge(1, 1, 4'h0);
        #1;
        check("gl_ignored", 1'b0, 64'(WC + 1));

        // Randomized traffic against the reference model.
        apply(0, 1, 4'h0);
        check("rnd_rst", m_granted, m_cnt);
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       s;
            logic [3:0] p;
            r = ($urandom_range(0, 99) >= 3);
            s = ($urandom_range(0, 99) >= 8);
            p = ($urandom_range(0, 99) < 25) ? PW : 4'($urandom_range(0, 15));
            apply(r, s, p);
            check("rnd", m_granted, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
